// File: rtl/sqrt_bus_master_if.sv
// Handshake and core-control signals between the system datapath, sqrt_bus_master and sqrt2.
// The shared IO_DATA bus is a separate inout port on the master.
interface sqrt_bus_master_if;
  logic        IN_VALID;
  logic        IN_READY;
  logic [15:0] IN_DATA;

  logic        OUT_VALID;
  logic        OUT_READY;
  logic [15:0] OUT_DATA;
  logic        OUT_IS_NAN;
  logic        OUT_IS_PINF;
  logic        OUT_IS_NINF;
  logic        OUT_TIMEOUT;
  logic [7:0]  OUT_CYCLES;

  logic        CORE_ENABLE;
  logic        CORE_RESULT;
  logic        CORE_IS_NAN;
  logic        CORE_IS_PINF;
  logic        CORE_IS_NINF;

  modport master (
    input  IN_VALID, IN_DATA, OUT_READY,
    input  CORE_RESULT, CORE_IS_NAN, CORE_IS_PINF, CORE_IS_NINF,
    output IN_READY, OUT_VALID, OUT_DATA, OUT_IS_NAN, OUT_IS_PINF, OUT_IS_NINF,
    output OUT_TIMEOUT, OUT_CYCLES, CORE_ENABLE
  );

  modport slave (
    output IN_VALID, IN_DATA, OUT_READY,
    output CORE_RESULT, CORE_IS_NAN, CORE_IS_PINF, CORE_IS_NINF,
    input  IN_READY, OUT_VALID, OUT_DATA, OUT_IS_NAN, OUT_IS_PINF, OUT_IS_NINF,
    input  OUT_TIMEOUT, OUT_CYCLES, CORE_ENABLE
  );
endinterface

// File: rtl/sqrt_bus_master.sv
// Host-side sequencer for one sqrt2 core: drives the operand on the shared bus for the load
// cycle, waits for RESULT or a timeout, and returns the captured result on a valid/ready port.
module sqrt_bus_master #(
  parameter int unsigned TIMEOUT_CYCLES = 32,
  parameter logic [15:0] TIMEOUT_WORD   = 16'h7E00
) (
  input  logic              CLK,
  input  logic              RST_N,
  sqrt_bus_master_if.master bus,
  inout  wire  [15:0]       CORE_IO_DATA
);

  typedef enum logic [1:0] {StIdle, StDrive, StWait, StResp} state_e;

  localparam logic [7:0] WaitLast = 8'(TIMEOUT_CYCLES - 1);

  state_e      state_q;
  logic        settled_q;
  logic        in_ready_q;
  logic        core_enable_q;
  logic [15:0] operand_q;
  logic [7:0]  cycles_q;
  logic [7:0]  wait_q;
  logic [7:0]  cycles_inc;
  logic        out_valid_q;
  logic [15:0] out_data_q;
  logic        out_nan_q;
  logic        out_pinf_q;
  logic        out_ninf_q;
  logic        out_timeout_q;
  logic [7:0]  out_cycles_q;

  assign cycles_inc = (cycles_q == 8'hFF) ? cycles_q : cycles_q + 8'd1;

  // Bus is driven only while the core is loading; released as soon as the state leaves DRIVE.
  assign CORE_IO_DATA = (state_q == StDrive) ? operand_q : 16'hzzzz;

  assign bus.IN_READY    = in_ready_q;
  assign bus.CORE_ENABLE = core_enable_q;
  assign bus.OUT_VALID   = out_valid_q;
  assign bus.OUT_DATA    = out_data_q;
  assign bus.OUT_IS_NAN  = out_nan_q;
  assign bus.OUT_IS_PINF = out_pinf_q;
  assign bus.OUT_IS_NINF = out_ninf_q;
  assign bus.OUT_TIMEOUT = out_timeout_q;
  assign bus.OUT_CYCLES  = out_cycles_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q       <= StIdle;
      settled_q     <= 1'b0;
      in_ready_q    <= 1'b0;
      core_enable_q <= 1'b0;
      operand_q     <= 16'h0000;
      cycles_q      <= 8'd0;
      wait_q        <= 8'd0;
      out_valid_q   <= 1'b0;
      out_data_q    <= 16'h0000;
      out_nan_q     <= 1'b0;
      out_pinf_q    <= 1'b0;
      out_ninf_q    <= 1'b0;
      out_timeout_q <= 1'b0;
      out_cycles_q  <= 8'd0;
    end else begin
      // One ENABLE-low edge after reset lets the core tri-state its bus register first.
      settled_q <= 1'b1;
      unique case (state_q)
        StIdle: begin
          in_ready_q <= 1'b1;
          if (bus.IN_VALID && in_ready_q) begin
            operand_q     <= bus.IN_DATA;
            cycles_q      <= 8'd0;
            in_ready_q    <= 1'b0;
            core_enable_q <= 1'b1;
            state_q       <= StDrive;
          end
        end
        StDrive: begin
          cycles_q <= cycles_inc;
          wait_q   <= 8'd0;
          state_q  <= StWait;
        end
        StWait: begin
          cycles_q <= cycles_inc;
          wait_q   <= wait_q + 8'd1;
          // A result on the timeout edge takes priority over the abort.
          if (bus.CORE_RESULT) begin
            out_data_q    <= CORE_IO_DATA;
            out_nan_q     <= bus.CORE_IS_NAN;
            out_pinf_q    <= bus.CORE_IS_PINF;
            out_ninf_q    <= bus.CORE_IS_NINF;
            out_timeout_q <= 1'b0;
            out_cycles_q  <= cycles_inc;
            out_valid_q   <= 1'b1;
            core_enable_q <= 1'b0;
            state_q       <= StResp;
          end else if (wait_q == WaitLast) begin
            out_data_q    <= TIMEOUT_WORD;
            out_nan_q     <= 1'b0;
            out_pinf_q    <= 1'b0;
            out_ninf_q    <= 1'b0;
            out_timeout_q <= 1'b1;
            out_cycles_q  <= cycles_inc;
            out_valid_q   <= 1'b1;
            core_enable_q <= 1'b0;
            state_q       <= StResp;
          end
        end
        StResp: begin
          if (bus.OUT_READY) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_sqrt_bus_master.sv
// Randomised scoreboard bench for sqrt_bus_master with a behavioural sqrt2 stand-in driving
// the shared bus, plus directed reset, timeout and back-pressure scenarios.
module tb_sqrt_bus_master;

  localparam int unsigned T       = 32;
  localparam logic [15:0] TO_WORD = 16'h7E00;

  typedef struct {
    logic [15:0] data;
    logic [2:0]  flags;    // {nan, pinf, ninf}
    logic        timeout;
    logic [7:0]  cycles;
    logic        cyc_chk;
  } exp_t;

  logic       CLK;
  logic       RST_N;
  wire [15:0] core_io_data;

  sqrt_bus_master_if bus ();

  sqrt_bus_master #(
    .TIMEOUT_CYCLES (T),
    .TIMEOUT_WORD   (TO_WORD)
  ) dut (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .bus          (bus),
    .CORE_IO_DATA (core_io_data)
  );

  int          checks = 0;
  int          errors = 0;
  exp_t        sb[$];
  logic [15:0] last_op;
  int          lat_mode;   // -1 never answers, 0 operand-derived latency, >0 fixed latency

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference sqrt2 behaviour: result word, flags and latency from operand class.
  function automatic logic is_special(input logic [15:0] op);
    return (op[14:10] == 5'h1F) || (op[15] && op[14:0] != 15'd0) || (op[14:0] == 15'd0);
  endfunction

  function automatic logic [15:0] f_data(input logic [15:0] op);
    if (op[14:10] == 5'h1F && op[9:0] != 10'd0) return 16'hFE00;
    if (op == 16'h7C00) return 16'h7C00;
    if (op[15] && op[14:0] != 15'd0) return 16'hFE00;
    if (op[14:0] == 15'd0) return op;
    if (op == 16'h4400) return 16'h4000;
    if (op == 16'h0001) return 16'h0C00;
    return {1'b0, 5'(op[14:10] / 2 + 7), op[9:0]};
  endfunction

  function automatic logic [2:0] f_flags(input logic [15:0] op);
    if (op[14:10] == 5'h1F && op[9:0] != 10'd0) return 3'b100;
    if (op == 16'h7C00) return 3'b010;
    if (op == 16'hFC00) return 3'b101;
    if (op[15] && op[14:0] != 15'd0) return 3'b100;
    return 3'b000;
  endfunction

  function automatic int f_lat(input logic [15:0] op);
    if (is_special(op)) return 1;
    return 2 + int'(op[2:0]);
  endfunction

  function automatic int eff_lat(input logic [15:0] op);
    if (lat_mode < 0) return 0;
    if (lat_mode == 0) return f_lat(op);
    return lat_mode;
  endfunction

  // Accept edge is 0, load edge 1, RESULT raised after edge 1+k, captured at edge 2+k;
  // the last WAIT edge is 1+T.
  function automatic exp_t expect_of(input logic [15:0] op);
    exp_t e;
    int   k = eff_lat(op);
    if (k == 0 || 2 + k > int'(T) + 1) e = '{TO_WORD, 3'b000, 1'b1, 8'd0, 1'b0};
    else e = '{f_data(op), f_flags(op), 1'b0, 8'(2 + k), 1'b1};
    return e;
  endfunction

  // sqrt2 stand-in.
  logic        core_busy, core_res, core_drive;
  logic [15:0] core_word;
  logic [2:0]  core_flags;
  int          core_cnt;
  int          en_low;

  assign core_io_data     = core_drive ? core_word : 16'hzzzz;
  assign bus.CORE_RESULT  = core_res;
  assign bus.CORE_IS_NAN  = core_flags[2];
  assign bus.CORE_IS_PINF = core_flags[1];
  assign bus.CORE_IS_NINF = core_flags[0];

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      core_busy  <= 1'b0;
      core_res   <= 1'b0;
      core_drive <= 1'b0;
      core_word  <= 16'h0000;
      core_flags <= 3'b000;
      core_cnt   <= 0;
      en_low     <= 0;
    end else begin
      en_low <= bus.CORE_ENABLE ? 0 : en_low + 1;
      if (!bus.CORE_ENABLE) begin
        core_busy  <= 1'b0;
        core_res   <= 1'b0;
        core_drive <= 1'b0;
      end else if (!core_busy) begin
        chk("enable_low_gap", 32'(en_low >= 2), 32'd1);
        chk("bus_load", 32'(core_io_data), 32'(last_op));
        core_busy  <= 1'b1;
        core_word  <= f_data(core_io_data);
        core_flags <= f_flags(core_io_data);
        core_cnt   <= eff_lat(core_io_data);
      end else if (core_cnt == 1) begin
        core_res   <= 1'b1;
        core_drive <= 1'b1;
        core_cnt   <= 0;
      end else if (core_cnt > 1) begin
        core_cnt <= core_cnt - 1;
      end
    end
  end

  // Monitor: compares on every output handshake and watches the bus while the core drives it.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (RST_N && core_drive) chk("bus_core_drive", 32'(core_io_data), 32'(core_word));
      if (RST_N && bus.OUT_VALID && bus.OUT_READY) begin
        if (sb.size() == 0) begin
          chk("unexpected_output", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("out_data", 32'(bus.OUT_DATA), 32'(e.data));
          chk("out_flags", 32'({bus.OUT_IS_NAN, bus.OUT_IS_PINF, bus.OUT_IS_NINF}),
              32'(e.flags));
          chk("out_timeout", 32'(bus.OUT_TIMEOUT), 32'(e.timeout));
          if (e.cyc_chk) chk("out_cycles", 32'(bus.OUT_CYCLES), 32'(e.cycles));
        end
      end
    end
  end

  task automatic send(input logic [15:0] op);
    int n = 0;
    bus.IN_DATA  = op;
    bus.IN_VALID = 1'b1;
    last_op      = op;
    @(negedge CLK);
    while (!bus.IN_READY && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (!bus.IN_READY) begin
      chk("accept_bound", 32'd0, 32'd1);
      bus.IN_VALID = 1'b0;
    end else begin
      sb.push_back(expect_of(op));
      @(posedge CLK);
      #1 bus.IN_VALID = 1'b0;
    end
  endtask

  task automatic collect(input int hold);
    int n = 0;
    @(negedge CLK);
    while (!bus.OUT_VALID && n < 100) begin
      @(negedge CLK);
      n++;
    end
    if (!bus.OUT_VALID) begin
      chk("result_bound", 32'd0, 32'd1);
    end else begin
      repeat (hold) @(posedge CLK);
      @(posedge CLK);
      #1 bus.OUT_READY = 1'b1;
      @(posedge CLK);
      #1 bus.OUT_READY = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] r;
    RST_N         = 1'b0;
    bus.IN_VALID  = 1'b0;
    bus.IN_DATA   = 16'h0000;
    bus.OUT_READY = 1'b0;
    lat_mode      = 0;
    last_op       = 16'h0000;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_in_ready", 32'(bus.IN_READY), 32'd0);
    chk("rst_out_valid", 32'(bus.OUT_VALID), 32'd0);
    chk("rst_enable", 32'(bus.CORE_ENABLE), 32'd0);
    chk("rst_outputs", 32'({bus.OUT_DATA, bus.OUT_CYCLES, bus.OUT_TIMEOUT, bus.OUT_IS_NAN}),
        32'd0);

    // Release with IN_VALID already high: ready after the first edge, accept on the second.
    bus.IN_DATA  = 16'h7C00;
    bus.IN_VALID = 1'b1;
    last_op      = 16'h7C00;
    @(negedge CLK);
    RST_N = 1'b1;
    #1 chk("settle_ready_low", 32'(bus.IN_READY), 32'd0);
    @(posedge CLK);
    #1;
    chk("settle_ready_high", 32'(bus.IN_READY), 32'd1);
    chk("settle_enable_low", 32'(bus.CORE_ENABLE), 32'd0);
    sb.push_back(expect_of(16'h7C00));
    @(posedge CLK);
    #1;
    chk("drive_ready_low", 32'(bus.IN_READY), 32'd0);
    chk("drive_enable", 32'(bus.CORE_ENABLE), 32'd1);
    bus.IN_VALID = 1'b0;
    collect(0);

    send(16'hC000);
    collect(1);
    send(16'h4400);
    collect(0);
    send(16'h0001);
    collect(0);
    send(16'hFC00);
    collect(2);

    // Core never answers: abort on the last WAIT edge, then hold the result under back-pressure.
    lat_mode = -1;
    send(16'h3C00);
    repeat (T) @(posedge CLK);
    #1 chk("timeout_not_early", 32'(bus.OUT_VALID), 32'd0);
    @(posedge CLK);
    #1;
    chk("timeout_valid", 32'(bus.OUT_VALID), 32'd1);
    chk("timeout_flag", 32'(bus.OUT_TIMEOUT), 32'd1);
    chk("timeout_enable", 32'(bus.CORE_ENABLE), 32'd0);
    repeat (5) begin
      @(posedge CLK);
      #1;
      chk("hold_valid", 32'(bus.OUT_VALID), 32'd1);
      chk("hold_data", 32'(bus.OUT_DATA), 32'(TO_WORD));
      chk("hold_in_ready", 32'(bus.IN_READY), 32'd0);
    end
    collect(0);

    // Result arriving on the timeout edge wins.
    lat_mode = int'(T) - 1;
    send(16'h3C00);
    collect(0);

    // Reset in the middle of WAIT discards the transaction.
    lat_mode = 20;
    send(16'h4400);
    repeat (4) @(posedge CLK);
    #3 RST_N = 1'b0;
    #1;
    chk("midrst_enable", 32'(bus.CORE_ENABLE), 32'd0);
    chk("midrst_out_valid", 32'(bus.OUT_VALID), 32'd0);
    chk("midrst_in_ready", 32'(bus.IN_READY), 32'd0);
    sb.delete();
    @(negedge CLK);
    RST_N    = 1'b1;
    lat_mode = 0;
    send(16'h4400);
    collect(0);

    for (int i = 0; i < 16; i++) begin
      r = 16'($urandom);
      send(r);
      collect(int'($urandom_range(0, 2)));
    end

    repeat (3) @(posedge CLK);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
